// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//   A shadow copy of the display value, decimal points, blanking mask and the
//   leading-zero-suppression enable is latched on iLOAD. The driver then lights
//   one digit per slot of SCAN_DIV clocks. Each slot opens with DEAD_CYCLES
//   clocks in which every anode is off, which prevents ghosting between digits.
//
// Ports
//   iCLK    system clock
//   iRST    synchronous reset, active high
//   iVALUE  hex nibbles; digit k = iVALUE[4k+3:4k], digit 0 is rightmost
//   iDP     per-digit decimal point request (1 = lit)
//   iBLANK  per-digit force-dark (1 = blank)
//   iLZS    leading-zero suppression enable
//   iLOAD   latch iVALUE/iDP/iBLANK/iLZS into the shadow registers
//   oSEG    segments {g,f,e,d,c,b,a}, active low
//   oDP     decimal point, active low
//   oAN     digit enables, active low, at most one low
//   oSLOT   one-cycle pulse on the first cycle of each slot
//
// Contains seg7_scan_lane, the per-digit decode and dark logic. The top
// instantiates one lane per digit and muxes the active lane onto the outputs.

module seg7_scan_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 2
) (
  input  logic [3:0]       i_nib,
  input  logic             i_dp,
  input  logic             i_blank,
  input  logic             i_lzs,
  input  logic [IDX_W-1:0] i_msnz,   // position of the most-significant nonzero nibble
  output logic [6:0]       o_seg,
  output logic             o_dp_n
);
  logic [6:0] w_dec;
  logic       w_dark;

  always_comb begin
    w_dec = 7'h7F;
    unique case (i_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h18;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      4'hF: w_dec = 7'h0E;
    endcase
  end

  // Digit 0 has LANE=0 and can never exceed i_msnz, so a zero value
  // still shows a single "0". A suppressed digit also loses its DP.
  assign w_dark = i_blank || (i_lzs && (IDX_W'(LANE) > i_msnz));
  assign o_seg  = w_dark ? 7'h7F : w_dec;
  assign o_dp_n = w_dark ? 1'b1  : ~i_dp;
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 64,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLANK,
  input  logic                    iLZS,
  input  logic                    iLOAD,
  output logic [6:0]              oSEG,
  output logic                    oDP,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oSLOT
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // shadow registers
  logic [NUM_DIGITS-1:0][3:0] r_val;
  logic [NUM_DIGITS-1:0]      r_dp;
  logic [NUM_DIGITS-1:0]      r_blank;
  logic                       r_lzs;

  // scan state
  logic [DIV_WIDTH-1:0]       r_presc;
  logic [IDX_W-1:0]           r_idx;

  // output registers
  logic [6:0]                 r_seg;
  logic                       r_dpo;
  logic [NUM_DIGITS-1:0]      r_an;
  logic                       r_slot;

  logic [NUM_DIGITS-1:0][6:0] w_seg_all;
  logic [NUM_DIGITS-1:0]      w_dpn_all;
  logic [IDX_W-1:0]           w_msnz;
  logic                       w_wrap;
  logic                       w_dead;
  logic [NUM_DIGITS-1:0]      w_an_on;

  // Highest nonzero nibble; 0 when the whole value is zero. Blanking is
  // deliberately ignored here so a blanked digit still counts as content.
  always_comb begin
    w_msnz = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_val[k] != 4'h0) w_msnz = IDX_W'(k);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg7_scan_lane #(.LANE(g), .IDX_W(IDX_W)) u_lane (
      .i_nib   (r_val[g]),
      .i_dp    (r_dp[g]),
      .i_blank (r_blank[g]),
      .i_lzs   (r_lzs),
      .i_msnz  (w_msnz),
      .o_seg   (w_seg_all[g]),
      .o_dp_n  (w_dpn_all[g])
    );
  end

  assign w_wrap  = (r_presc == DIV_WIDTH'(SCAN_DIV - 1));
  assign w_dead  = (r_presc <  DIV_WIDTH'(DEAD_CYCLES));
  assign w_an_on = ~(NUM_DIGITS'(1) << r_idx);

  // The output stage samples the current scan state and shadow, so the
  // outputs trail the prescaler by one register. A load at edge t is
  // therefore visible on the pins after edge t+1.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_val   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_lzs   <= 1'b0;
      r_presc <= '0;
      r_idx   <= '0;
      r_seg   <= 7'h7F;
      r_dpo   <= 1'b1;
      r_an    <= '1;
      r_slot  <= 1'b0;
    end else begin
      if (iLOAD) begin
        r_val   <= iVALUE;
        r_dp    <= iDP;
        r_blank <= iBLANK;
        r_lzs   <= iLZS;
      end
      r_seg  <= w_seg_all[r_idx];
      r_dpo  <= w_dpn_all[r_idx];
      r_an   <= w_dead ? '1 : w_an_on;
      r_slot <= (r_presc == '0);
      if (w_wrap) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign oSEG  = r_seg;
  assign oDP   = r_dpo;
  assign oAN   = r_an;
  assign oSLOT = r_slot;
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int ND   = 4;
  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic [4*ND-1:0] iVALUE = '0;
  logic [ND-1:0] iDP = '0;
  logic [ND-1:0] iBLANK = '0;
  logic          iLZS = 1'b0;
  logic          iLOAD = 1'b0;
  logic [6:0]    oSEG;
  logic          oDP;
  logic [ND-1:0] oAN;
  logic          oSLOT;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .DEAD_CYCLES(DEAD), .DIV_WIDTH(16)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALUE(iVALUE), .iDP(iDP), .iBLANK(iBLANK),
    .iLZS(iLZS), .iLOAD(iLOAD), .oSEG(oSEG), .oDP(oDP), .oAN(oAN), .oSLOT(oSLOT)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: time since release plus the shadow contents
  int              m_n;
  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_dp, m_blank;
  logic            m_lzs;
  logic [6:0]      e_seg;
  logic            e_dp, e_slot;
  logic [ND-1:0]   e_an;
  logic [6:0]      tbl [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected pins for the edge that ends with m_n prior scan cycles,
  // derived straight from slot arithmetic and the display rules.
  task automatic model_out();
    int ph, dig, top;
    logic [3:0] nib;
    logic dark;
    ph  = m_n % DIV;
    dig = (m_n / DIV) % ND;
    top = 0;
    for (int k = 0; k < ND; k++) if (((m_val >> (4*k)) & 16'hF) != 0) top = k;
    nib  = 4'((m_val >> (4*dig)) & 16'hF);
    dark = m_blank[dig] || (m_lzs && dig > top);
    e_seg  = dark ? 7'h7F : tbl[nib];
    e_dp   = dark ? 1'b1 : ~m_dp[dig];
    e_slot = (ph == 0);
    e_an   = (ph < DEAD) ? '1 : ~(ND'(1) << dig);
  endtask

  task automatic tick();
    @(posedge iCLK);
    if (iRST) begin
      m_n = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lzs = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_slot = 1'b0;
    end else begin
      model_out();
      m_n++;
      if (iLOAD) begin m_val = iVALUE; m_dp = iDP; m_blank = iBLANK; m_lzs = iLZS; end
    end
    #1;
    chk("seg",  32'(oSEG),  32'(e_seg));
    chk("dp",   32'(oDP),   32'(e_dp));
    chk("an",   32'(oAN),   32'(e_an));
    chk("slot", 32'(oSLOT), 32'(e_slot));
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl, input logic lzs);
    iVALUE = v; iDP = dp; iBLANK = bl; iLZS = lzs; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
    iVALUE = 16'($urandom); iDP = 4'($urandom); iBLANK = 4'($urandom); iLZS = 1'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_n = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lzs = 1'b0;

    // reset held, then release and scan the zero shadow
    run(3);
    iRST = 1'b0;
    run(20);

    // directed scenarios from the display rules
    load(16'h12AF, 4'b0000, 4'b0000, 1'b0); run(20);
    load(16'h0050, 4'b0000, 4'b0000, 1'b1); run(17);
    load(16'h0000, 4'b1111, 4'b0000, 1'b1); run(17);
    load(16'h8888, 4'b0100, 4'b0001, 1'b0); run(17);
    load(16'h0300, 4'b1111, 4'b0100, 1'b1); run(17);

    // mid-slot load on digit 1
    run(5);
    load(16'h4321, 4'b0010, 4'b0000, 1'b0); run(8);

    // reset mid-slot on digit 2
    run(3);
    iRST = 1'b1; tick(); iRST = 1'b0; run(20);

    // randomized traffic with sparse loads and occasional resets
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        iRST = 1'b1; iLOAD = 1'($urandom); tick(); iRST = 1'b0; iLOAD = 1'b0;
      end else if (r < 18) begin
        load(16'($urandom) & {{4{1'($urandom)}}, {4{1'($urandom)}}, {4{1'($urandom)}}, {4{1'($urandom)}}},
             4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
      end else begin
        iVALUE = 16'($urandom); iDP = 4'($urandom);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
